// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - front-end stall/flush sequencer with redirect on mispredict or exception
// Optional perf counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rob_full,
    input  logic              id_stall_req,
    input  logic              if_stall_req,
    input  logic              mispredict_valid,
    input  logic [ADDR_W-1:0] mispredict_target,
    input  logic              exception_valid,
    input  logic [ADDR_W-1:0] exception_target,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_idrob,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_flush_count,
    output logic [31:0]       perf_mispredict_count
`endif
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              flush_nxt, rv_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic              take_exc, take_mis;

    // Mispredicts seen while flushing come from squashed instructions and are dropped.
    assign take_exc = exception_valid;
    assign take_mis = mispredict_valid && !exception_valid && (state == RUN);
    assign busy     = (state == FLUSH);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush_nxt = flush;
        rv_nxt    = 1'b0;
        pc_nxt    = redirect_pc;
        if (take_exc || take_mis) begin
            state_nxt = FLUSH;
            cnt_nxt   = CNT_INIT;
            flush_nxt = 1'b1;
            rv_nxt    = 1'b1;
            pc_nxt    = take_exc ? exception_target : mispredict_target;
        end else if (state == FLUSH) begin
            if (cnt == 4'd0) begin
                state_nxt = RUN;
                flush_nxt = 1'b0;
            end else begin
                cnt_nxt = cnt - 4'd1;
            end
        end
    end

    // Stalls are dropped while flushing so the clear reaches every register.
    always_comb begin
        stall_idrob = 1'b0;
        stall_id    = 1'b0;
        stall_if    = 1'b0;
        if (rst && state == RUN) begin
            stall_idrob = rob_full;
            stall_id    = rob_full | id_stall_req;
            stall_if    = rob_full | id_stall_req | if_stall_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= RUN;
            cnt            <= 4'd0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            flush          <= flush_nxt;
            redirect_valid <= rv_nxt;
            redirect_pc    <= pc_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cycles     <= '0;
            perf_flush_count      <= '0;
            perf_mispredict_count <= '0;
        end else begin
            if (state == RUN && stall_if && perf_stall_cycles != 32'hffffffff)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if ((take_exc || take_mis) && perf_flush_count != 32'hffffffff)
                perf_flush_count <= perf_flush_count + 32'd1;
            if (take_mis && perf_mispredict_count != 32'hffffffff)
                perf_mispredict_count <= perf_mispredict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_pipe_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst, rob_full, id_stall_req, if_stall_req;
    logic        mispredict_valid, exception_valid;
    logic [31:0] mispredict_target, exception_target;
    logic        stall_if, stall_id, stall_idrob, flush, redirect_valid, busy;
    logic [31:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_count, perf_mispredict_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rob_full(rob_full), .id_stall_req(id_stall_req),
        .if_stall_req(if_stall_req), .mispredict_valid(mispredict_valid),
        .mispredict_target(mispredict_target), .exception_valid(exception_valid),
        .exception_target(exception_target), .stall_if(stall_if), .stall_id(stall_id),
        .stall_idrob(stall_idrob), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
`ifdef PIPE_CTRL_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count),
        .perf_mispredict_count(perf_mispredict_count)
`endif
    );

    typedef struct {
        logic        r, rob, idr, ifr, mv;
        logic [31:0] mt;
        logic        ev;
        logic [31:0] et;
        logic        s_if, s_id, s_rob, fl, rv;
        logic [31:0] pc;
        logic        bsy;
    } vec_t;

    vec_t vecs[21];

    // Reference model: remaining flush cycles, pending pulse, last PC, event counts.
    int          m_left;
    logic        m_rv;
    logic [31:0] m_pc;
    int          m_ps, m_fc, m_mc;

    function automatic vec_t mk(logic r, logic rob, logic idr, logic ifr, logic mv,
                                logic [31:0] mt, logic ev, logic [31:0] et, logic s_if,
                                logic s_id, logic s_rob, logic fl, logic rv,
                                logic [31:0] pc, logic bsy);
        vec_t v;
        v.r = r; v.rob = rob; v.idr = idr; v.ifr = ifr; v.mv = mv; v.mt = mt;
        v.ev = ev; v.et = et; v.s_if = s_if; v.s_id = s_id; v.s_rob = s_rob;
        v.fl = fl; v.rv = rv; v.pc = pc; v.bsy = bsy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rob, input logic idr, input logic ifr,
                         input logic mv, input logic [31:0] mt, input logic ev,
                         input logic [31:0] et);
        @(negedge clk);
        rst = r; rob_full = rob; id_stall_req = idr; if_stall_req = ifr;
        mispredict_valid = mv; mispredict_target = mt;
        exception_valid = ev; exception_target = et;
        #1;
    endtask

    function automatic logic exp_sif();
        return rst && m_left == 0 && (rob_full | id_stall_req | if_stall_req);
    endfunction

    task automatic model_edge();
        logic acc_e, acc_m;
        @(posedge clk);
        if (!rst) begin
            m_left = 0; m_rv = 1'b0; m_pc = '0; m_ps = 0; m_fc = 0; m_mc = 0;
        end else begin
            acc_e = exception_valid;
            acc_m = mispredict_valid && !exception_valid && m_left == 0;
            if (exp_sif()) m_ps++;
            if (acc_e || acc_m) begin
                m_left = FC;
                m_rv   = 1'b1;
                m_pc   = acc_e ? exception_target : mispredict_target;
                m_fc++;
                if (acc_m) m_mc++;
            end else begin
                m_rv = 1'b0;
                if (m_left > 0) m_left--;
            end
        end
    endtask

    task automatic chk_model(input int i);
        logic run;
        run = rst && m_left == 0;
        chk($sformatf("rnd%0d stall_if", i), {31'd0, stall_if}, {31'd0, exp_sif()});
        chk($sformatf("rnd%0d stall_id", i), {31'd0, stall_id},
            {31'd0, run & (rob_full | id_stall_req)});
        chk($sformatf("rnd%0d stall_idrob", i), {31'd0, stall_idrob}, {31'd0, run & rob_full});
        chk($sformatf("rnd%0d flush", i), {31'd0, flush}, {31'd0, m_left > 0});
        chk($sformatf("rnd%0d busy", i), {31'd0, busy}, {31'd0, m_left > 0});
        chk($sformatf("rnd%0d redirect_valid", i), {31'd0, redirect_valid}, {31'd0, m_rv});
        chk($sformatf("rnd%0d redirect_pc", i), redirect_pc, m_pc);
    endtask

    initial begin
        vecs[0]  = mk(0,1,0,0, 0,0, 0,0,                        0,0,0,0,0,32'h0,0);
        vecs[1]  = mk(0,1,0,0, 0,0, 0,0,                        0,0,0,0,0,32'h0,0);
        vecs[2]  = mk(1,1,0,0, 0,0, 0,0,                        1,1,1,0,0,32'h0,0);
        vecs[3]  = mk(1,0,0,1, 0,0, 0,0,                        1,0,0,0,0,32'h0,0);
        vecs[4]  = mk(1,0,1,0, 0,0, 0,0,                        1,1,0,0,0,32'h0,0);
        vecs[5]  = mk(1,1,0,0, 1,32'hbfc00040, 0,0,             1,1,1,0,0,32'h0,0);
        vecs[6]  = mk(1,1,1,1, 0,0, 0,0,                        0,0,0,1,1,32'hbfc00040,1);
        vecs[7]  = mk(1,1,0,0, 0,0, 0,0,                        0,0,0,1,0,32'hbfc00040,1);
        vecs[8]  = mk(1,0,0,0, 0,0, 0,0,                        0,0,0,0,0,32'hbfc00040,0);
        vecs[9]  = mk(1,0,0,0, 1,32'hbfc00040, 1,32'hbfc00380, 0,0,0,0,0,32'hbfc00040,0);
        vecs[10] = mk(1,0,0,0, 1,32'h12345678, 1,32'h80000180, 0,0,0,1,1,32'hbfc00380,1);
        vecs[11] = mk(1,0,0,0, 0,0, 0,0,                        0,0,0,1,1,32'h80000180,1);
        vecs[12] = mk(1,0,0,0, 0,0, 0,0,                        0,0,0,1,0,32'h80000180,1);
        vecs[13] = mk(1,0,0,0, 0,0, 0,0,                        0,0,0,0,0,32'h80000180,0);
        vecs[14] = mk(1,0,0,0, 1,32'h11111110, 0,0,             0,0,0,0,0,32'h80000180,0);
        vecs[15] = mk(1,0,0,0, 1,32'h22222220, 0,0,             0,0,0,1,1,32'h11111110,1);
        vecs[16] = mk(1,0,0,0, 0,0, 0,0,                        0,0,0,1,0,32'h11111110,1);
        vecs[17] = mk(1,0,0,0, 1,32'h33333330, 0,0,             0,0,0,0,0,32'h11111110,0);
        vecs[18] = mk(0,1,0,0, 0,0, 0,0,                        0,0,0,1,1,32'h33333330,1);
        vecs[19] = mk(1,0,0,0, 0,0, 0,0,                        0,0,0,0,0,32'h0,0);
        vecs[20] = mk(1,1,0,1, 0,0, 0,0,                        1,1,1,0,0,32'h0,0);

        drive(0, 1, 0, 0, 0, 0, 0, 0);
        model_edge();

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].rob, vecs[i].idr, vecs[i].ifr,
                  vecs[i].mv, vecs[i].mt, vecs[i].ev, vecs[i].et);
            chk($sformatf("vec%0d stall_if", i), {31'd0, stall_if}, {31'd0, vecs[i].s_if});
            chk($sformatf("vec%0d stall_id", i), {31'd0, stall_id}, {31'd0, vecs[i].s_id});
            chk($sformatf("vec%0d stall_idrob", i), {31'd0, stall_idrob}, {31'd0, vecs[i].s_rob});
            chk($sformatf("vec%0d flush", i), {31'd0, flush}, {31'd0, vecs[i].fl});
            chk($sformatf("vec%0d redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].rv});
            chk($sformatf("vec%0d redirect_pc", i), redirect_pc, vecs[i].pc);
            chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].bsy});
            model_edge();
        end

`ifdef PIPE_CTRL_PERF_EN
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_edge();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 1, 0, 0, 0, 0);
            model_edge();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 1, 32'hbfc00040, 0, 0);
            model_edge();
            for (int j = 0; j < 3; j++) begin
                drive(1, 0, 0, 0, 0, 0, 0, 0);
                model_edge();
            end
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("perf_stall_cycles", perf_stall_cycles, 32'd5);
        chk("perf_flush_count", perf_flush_count, 32'd2);
        chk("perf_mispredict_count", perf_mispredict_count, 32'd2);
        model_edge();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        model_edge();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("perf_stall_cycles reset", perf_stall_cycles, 32'd0);
        chk("perf_flush_count reset", perf_flush_count, 32'd0);
        chk("perf_mispredict_count reset", perf_mispredict_count, 32'd0);
        model_edge();
`endif

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(31, 0) != 0, $urandom_range(3, 0) == 0,
                  $urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                  $urandom_range(5, 0) == 0, $urandom, $urandom_range(7, 0) == 0, $urandom);
            chk_model(i);
            model_edge();
        end

`ifdef PIPE_CTRL_PERF_EN
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rnd perf_stall_cycles", perf_stall_cycles, m_ps);
        chk("rnd perf_flush_count", perf_flush_count, m_fc);
        chk("rnd perf_mispredict_count", perf_mispredict_count, m_mc);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central front-end sequencer for the out-of-order core.
- Generates stall and flush controls for the IF, IF/ID and ID/IDROB pipeline registers.
- Sequences recovery after branch mispredicts (reported by the ROB/branch unit) and exceptions (reported at commit), and drives the fetch redirect.
- Sits between the ROB/commit logic and the front-end stages.

Parameters:
FLUSH_CYCLES, 2, cycles the front end is held flushed after a redirect (1..15)
ADDR_W, 32, width of redirect PC (matches ADDR_BUS)

Ports:
clk  input  1  clock
rst  input  1  reset
rob_full  input  1  ROB cannot accept an entry this cycle
id_stall_req  input  1  ID needs a hold, e.g. rename/RSID unavailable
if_stall_req  input  1  fetch waiting on instruction memory
mispredict_valid  input  1  branch unit reports a mispredict
mispredict_target  input  ADDR_W  correct target PC
exception_valid  input  1  commit stage raises an exception or ERET
exception_target  input  ADDR_W  handler PC or EPC
stall_if  output  1  hold PC register
stall_id  output  1  hold IF/ID register
stall_idrob  output  1  hold ID/IDROB register
flush  output  1  clear IF/ID and ID/IDROB contents
redirect_valid  output  1  one-cycle pulse: load redirect_pc into PC
redirect_pc  output  ADDR_W  new fetch PC
busy  output  1  recovery in progress (state != RUN)

Behaviour:
- Reset: rst synchronous, active-low. While rst==0 at posedge: state=RUN, counter=0, flush=0, redirect_valid=0, redirect_pc=0.
- Stall outputs are combinational; while rst==0 they read 0.
- States:
  - RUN: normal operation.
  - FLUSH: front end held cleared; counter runs.
  - STALL_HOLD: not used. Only two states exist; the encoding is a 1-bit state register.
- RUN:
  - stall_idrob = rob_full.
  - stall_id = rob_full | id_stall_req.
  - stall_if = stall_id | if_stall_req.
  - flush = 0.
- Event capture at posedge in any state, priority exception_valid > mispredict_valid:
  - redirect_pc <= the chosen target.
  - redirect_valid <= 1 for exactly one cycle.
  - flush <= 1.
  - state <= FLUSH.
  - counter <= FLUSH_CYCLES-1.
- FLUSH:
  - flush=1 every cycle.
  - stall_if/stall_id/stall_idrob forced 0, so the flush propagates regardless of stall requests.
  - Counter decrements each cycle. At 0 with no new event: state <= RUN and flush <= 0 on the following edge.
  - Total flush high time is FLUSH_CYCLES cycles.
- Latency: event at edge N → redirect_valid and flush high during cycle N+1 (registered).
- Simultaneous exception and mispredict: exception wins; the mispredict is dropped.
- Event arriving during FLUSH:
  - exception_valid: restarts the counter, updates redirect_pc, re-pulses redirect_valid.
  - mispredict_valid: ignored (stale, from flushed instructions).
- redirect_pc holds its last value when redirect_valid=0.
- busy = (state==FLUSH).
- Reset mid-FLUSH: immediate return to the reset values at that edge.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined, add three output ports, each 32-bit and saturating at 32'hffffffff, cleared by reset:
  - perf_stall_cycles: counts cycles in RUN with stall_if=1.
  - perf_flush_count: counts accepted redirect events.
  - perf_mispredict_count: counts accepted mispredicts only.
- When undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset held 2 cycles with rob_full=1 → all outputs 0. After release in RUN with rob_full=1 → stall_idrob=stall_id=stall_if=1, flush=0.
2. In RUN, if_stall_req=1 only → stall_if=1, stall_id=0, stall_idrob=0. id_stall_req=1 only → stall_if=stall_id=1, stall_idrob=0.
3. mispredict_valid=1, target 32'hbfc00040, for 1 cycle → next cycle:
   - redirect_valid=1 and redirect_pc=32'hbfc00040 for 1 cycle;
   - flush=1 and busy=1 for exactly 2 cycles, with stalls 0 despite rob_full=1;
   - then RUN.
4. Same-cycle exception_valid (32'hbfc00380) and mispredict_valid (32'hbfc00040) → redirect_pc=32'hbfc00380, single redirect pulse.
5. Exception arriving in the 1st FLUSH cycle (target 32'h80000180) → second redirect pulse with the new PC, flush extended to 2 cycles counted from the new event. A mispredict in the same window → ignored.
6. With PIPE_CTRL_PERF_EN defined:
   - 5 stall cycles plus 2 mispredicts → perf_stall_cycles=5, perf_flush_count=2, perf_mispredict_count=2.
   - rst low → all counters 0.
